seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Parametrised multi-cycle unsigned ALU: ADD, SUB, MUL, DIV on WIDTH-bit operands.
//  Operands are taken in with a valid/ready handshake. ADD/SUB finish in one cycle.
//  MUL (shift-add) and DIV (restoring) are iterative. The result is held until the consumer takes it.
//  Sits between the operand/opcode source and the result register file or pad outputs.
// PARAMETERS
//  WIDTH   8   operand width in bits; legal range 2..32. The result is 2*WIDTH bits wide.
// PORTS
//  clk        in   1        single clock; all state changes on the rising edge
//  rst        in   1        synchronous, active-low reset (0 = reset, sampled on clk)
//  in_valid   in   1        operands and opcode are valid
//  in_ready   out  1        block can accept a new operation
//  op         in   2        00 ADD, 01 SUB, 10 MUL, 11 DIV
//  a          in   WIDTH    operand A (dividend for DIV)
//  b          in   WIDTH    operand B (divisor for DIV)
//  out_valid  out  1        result and flags are valid
//  out_ready  in   1        consumer takes the result
//  result     out  2*WIDTH  ADD/SUB: {0..,carry,sum}; MUL: product; DIV: {remainder,quotient}
//  flag_carry out  1        ADD: carry out; SUB: borrow (a<b); 0 for MUL/DIV
//  flag_zero  out  1        ADD/SUB: sum==0; MUL: product==0; DIV: quotient==0
//  flag_dbz   out  1        DIV with b==0
// BEHAVIOUR
//  - Reset (rst==0 at an edge): state=IDLE; out_valid, result and all flags = 0; iteration counter = 0.
//  - in_ready = (state==IDLE) && rst. No new op is accepted while BUSY or DONE.
//  - Accept means in_valid && in_ready at an edge. op, a and b are captured into internal registers at that edge.
//  - FSM states and transitions:
//      IDLE --accept ADD/SUB--> DONE
//      IDLE --accept MUL--> BUSY
//      IDLE --accept DIV, b!=0--> BUSY
//      IDLE --accept DIV, b==0--> DONE
//      BUSY --counter reaches WIDTH-1--> DONE
//      DONE --out_valid && out_ready--> IDLE
//  - Latency is counted from the accept edge to the first cycle with out_valid=1.
//      ADD/SUB and DIV-by-zero: 1 cycle.
//      MUL and DIV: WIDTH+1 cycles (WIDTH iterations in BUSY, then DONE).
//  - ADD: result = {WIDTH-1 zeros, carry, a+b mod 2^WIDTH}.
//  - SUB: result low WIDTH bits = (a-b) mod 2^WIDTH, upper bits = 0; flag_carry = (a<b).
//  - MUL: each iteration adds the multiplicand when the current multiplier LSB is 1, then shifts. Result is the full 2*WIDTH product.
//  - DIV: restoring division, one quotient bit per iteration, MSB first.
//      result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder.
//  - DIV by zero: quotient = all ones, remainder = a, flag_dbz = 1, flag_zero = 0.
//  - In DONE, result and flags stay stable until out_ready is seen. The op, a and b inputs are ignored there.
//  - out_valid is deasserted the cycle after the handshake; result keeps its last value.
//  - Reset while BUSY or DONE aborts the operation immediately. No out_valid pulse follows.
//  - out_ready while out_valid==0 has no effect.
// STRUCTURE
//  - seq_alu_pkg holds:
//      opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11;
//      state encodings ST_IDLE, ST_BUSY, ST_DONE.
//  - Counter width = $clog2(WIDTH), a localparam derived from WIDTH.
//  - One sub-module, seq_alu_iter: combinational single step for MUL (add/shift) and DIV (trial subtract/shift), selected by op.
//  - The top level owns the FSM, the counter, the operand/accumulator registers and the handshake.
// TESTING (WIDTH=8 unless noted)
//  - ADD a=200 b=100 -> out_valid 1 cycle after accept; result=16'h012C, carry=1, zero=0.
//  - SUB a=3 b=5 -> result=16'h00FE, carry(borrow)=1. Then SUB a=7 b=7 -> result=0, zero=1, carry=0.
//  - MUL a=255 b=255 -> out_valid exactly 9 cycles after accept; result=16'hFE01. in_ready=0 throughout.
//  - DIV a=100 b=7 -> after 9 cycles result=16'h020E (rem 2, quot 14); dbz=0.
//  - DIV a=42 b=0 -> after 1 cycle result=16'h2AFF, dbz=1.
//  - Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and flags stable, in_ready=0, new in_valid ignored.
//  - Reset mid-operation: drop rst to 0 during cycle 4 of a MUL -> next cycle out_valid=0, result=0, in_ready=1 once rst=1.
//  - WIDTH=16: DIV 16'hFFFF / 16'h0100 -> quotient 16'h00FF, remainder 16'h00FF; latency 17 cycles.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state encodings for the sequential ALU.
package seq_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]         op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] opa_o,
    output logic [WIDTH-1:0]   opb_o
);

    logic [WIDTH:0] shifted;
    logic           take;

    always_comb begin
        // Divide: partial remainder picks up the next dividend bit, MSB first
        shifted = {acc_i[WIDTH-1:0], opa_i[WIDTH-1]};
        take    = (shifted >= {1'b0, opb_i});
        acc_o   = acc_i;
        opa_o   = opa_i;
        opb_o   = opb_i;
        if (op_i == OP_MUL) begin
            acc_o = acc_i + (opb_i[0] ? opa_i : '0);
            opa_o = {opa_i[2*WIDTH-2:0], 1'b0};
            opb_o = {1'b0, opb_i[WIDTH-1:1]};
        end else begin
            acc_o = {{(WIDTH-1){1'b0}}, (take ? (shifted - {1'b0, opb_i}) : shifted)};
            opa_o = {{WIDTH{1'b0}}, opa_i[WIDTH-2:0], take};
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB, iterative MUL/DIV, valid/ready on both sides.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_carry,
    output logic               flag_zero,
    output logic               flag_dbz
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               carry_q, carry_d, zero_q, zero_d, dbz_q, dbz_d;
    logic               out_valid_q, out_valid_d;

    logic [2*WIDTH-1:0] acc_nx, opa_nx;
    logic [WIDTH-1:0]   opb_nx;
    logic [WIDTH:0]     sum_ext, diff_ext;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .op_i  (op_q),
        .acc_i (acc_q),
        .opa_i (opa_q),
        .opb_i (opb_q),
        .acc_o (acc_nx),
        .opa_o (opa_nx),
        .opb_o (opb_nx)
    );

    assign in_ready   = (state_q == ST_IDLE) && rst;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign flag_carry = carry_q;
    assign flag_zero  = zero_q;
    assign flag_dbz   = dbz_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    acc_d = '0;
                    opa_d = {{WIDTH{1'b0}}, a};
                    opb_d = b;
                    cnt_d = '0;
                    if (op == OP_ADD || op == OP_SUB) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        dbz_d       = 1'b0;
                        if (op == OP_ADD) begin
                            result_d = {{(WIDTH-1){1'b0}}, sum_ext};
                            carry_d  = sum_ext[WIDTH];
                            zero_d   = (sum_ext[WIDTH-1:0] == '0);
                        end else begin
                            result_d = {{WIDTH{1'b0}}, diff_ext[WIDTH-1:0]};
                            carry_d  = diff_ext[WIDTH];
                            zero_d   = (diff_ext[WIDTH-1:0] == '0);
                        end
                    end else if (op == OP_DIV && b == '0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        result_d    = {a, {WIDTH{1'b1}}};
                        carry_d     = 1'b0;
                        zero_d      = 1'b0;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                acc_d = acc_nx;
                opa_d = opa_nx;
                opb_d = opb_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    // Last iteration's outputs go straight into the result register
                    state_d     = ST_DONE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    carry_d     = 1'b0;
                    dbz_d       = 1'b0;
                    if (op_q == OP_MUL) begin
                        result_d = acc_nx;
                        zero_d   = (acc_nx == '0);
                    end else begin
                        result_d = {acc_nx[WIDTH-1:0], opa_nx[WIDTH-1:0]};
                        zero_d   = (opa_nx[WIDTH-1:0] == '0);
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: WIDTH=8 instance for all ops plus a WIDTH=16 divide.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic [15:0] result;
    logic        flag_carry, flag_zero, flag_dbz;

    logic        in_valid16, out_ready16;
    logic        in_ready16, out_valid16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic [31:0] result16;
    logic        carry16, zero16, dbz16;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_dbz(flag_dbz)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
        .flag_carry(carry16), .flag_zero(zero16), .flag_dbz(dbz16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one op on the 8-bit DUT and wait (bounded) for out_valid
    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output bit ready_seen);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 60) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        $display("txn op=%0d a=%0d b=%0d latency=%0d result=%h c=%b z=%b dbz=%b",
                 o, x, y, lat, result, flag_carry, flag_zero, flag_dbz);
    endtask

    task automatic consume8;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        bit          rdy;
        bit          stable;
        logic [15:0] held;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'd0);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("rst_in_ready_high", 64'(in_ready), 64'd1);

        // ADD 200+100
        run8(2'b00, 8'd200, 8'd100, lat, rdy);
        check("add_lat", 64'(lat), 64'd1);
        check("add_result", 64'(result), 64'h012C);
        check("add_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b100);
        consume8();
        check("add_release_valid", 64'(out_valid), 64'd0);
        check("add_release_ready", 64'(in_ready), 64'd1);
        check("add_result_kept", 64'(result), 64'h012C);

        // SUB with borrow, then SUB to zero
        run8(2'b01, 8'd3, 8'd5, lat, rdy);
        check("sub_result", 64'(result), 64'h00FE);
        check("sub_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b100);
        consume8();
        run8(2'b01, 8'd7, 8'd7, lat, rdy);
        check("sub0_lat", 64'(lat), 64'd1);
        check("sub0_result", 64'(result), 64'h0000);
        check("sub0_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b010);
        consume8();

        // MUL 255*255
        run8(2'b10, 8'd255, 8'd255, lat, rdy);
        check("mul_lat", 64'(lat), 64'd9);
        check("mul_ready_busy", 64'(rdy), 64'd0);
        check("mul_result", 64'(result), 64'hFE01);
        check("mul_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b000);
        consume8();

        // MUL by zero
        run8(2'b10, 8'd0, 8'd123, lat, rdy);
        check("mul0_result", 64'(result), 64'h0000);
        check("mul0_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b010);
        consume8();

        // DIV 100/7
        run8(2'b11, 8'd100, 8'd7, lat, rdy);
        check("div_lat", 64'(lat), 64'd9);
        check("div_result", 64'(result), 64'h020E);
        check("div_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b000);
        consume8();

        // DIV with quotient zero
        run8(2'b11, 8'd5, 8'd7, lat, rdy);
        check("divq0_result", 64'(result), 64'h0500);
        check("divq0_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b010);
        consume8();

        // DIV by zero
        run8(2'b11, 8'd42, 8'd0, lat, rdy);
        check("dbz_lat", 64'(lat), 64'd1);
        check("dbz_result", 64'(result), 64'h2AFF);
        check("dbz_flags", 64'({flag_carry, flag_zero, flag_dbz}), 64'b001);
        consume8();

        // Backpressure: hold result 5 cycles while a new op is offered
        run8(2'b00, 8'd1, 8'd2, lat, rdy);
        held = result;
        stable = 1'b1;
        rdy = 1'b0;
        op = 2'b10; a = 8'd9; b = 8'd9; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (result !== held || out_valid !== 1'b1 || flag_carry !== 1'b0) stable = 1'b0;
            if (in_ready) rdy = 1'b1;
        end
        in_valid = 1'b0;
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_in_ready", 64'(rdy), 64'd0);
        check("bp_result", 64'(result), 64'h0003);
        consume8();
        @(negedge clk);
        check("bp_no_new_op", 64'(out_valid), 64'd0);

        // Reset in cycle 4 of a MUL
        @(negedge clk);
        op = 2'b10; a = 8'd13; b = 8'd11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 64'(out_valid), 64'd0);
        check("rstmid_result", 64'(result), 64'd0);
        rst = 1'b1;
        #1;
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        rdy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) rdy = 1'b1;
        end
        check("rstmid_no_pulse", 64'(rdy), 64'd0);
        $display("txn reset-abort mul a=13 b=11 result=%h", result);

        // WIDTH=16 divide
        @(negedge clk);
        op16 = 2'b11; a16 = 16'hFFFF; b16 = 16'h0100; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        $display("txn w16 div a=ffff b=0100 latency=%0d result=%h", lat, result16);
        check("w16_lat", 64'(lat), 64'd17);
        check("w16_result", 64'(result16), 64'h00FF00FF);
        check("w16_dbz", 64'(dbz16), 64'd0);
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("w16_release", 64'(out_valid16), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
